fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage RV32I core. Holds the PC, drives the
//  instruction-memory address, and captures instr/PC into the ID stage. Executes the stall_if,
//  stall_id and flush_id controls issued by the hazard unit, and redirects on EX-resolved
//  branches/jumps (ex_pc_src, ex_pc_target). Keeps bubble/fetch counters for performance debug.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  addi x0,x0,0; injected into ID on flush/reset
//  CNT_W      32             width of performance counters
// PORTS
//  clk            in   1      core clock, rising edge
//  rst            in   1      asynchronous reset, active-high
//  stall_if       in   1      hold PC (load-use stall)
//  stall_id       in   1      hold IF/ID register
//  flush_id       in   1      replace IF/ID contents with a bubble
//  ex_pc_src      in   1      taken branch/jump resolved in EX
//  ex_pc_target   in   32     redirect target from EX
//  imem_addr      out  32     instruction memory address (= PC), combinational read
//  imem_rdata     in   32     instruction word for imem_addr, same cycle
//  id_instr       out  32     registered instruction to decode
//  id_pc          out  32     PC of id_instr
//  id_pc_plus4    out  32     id_pc + 4
//  id_valid       out  1      0 = id_instr is an injected bubble
//  fetch_count    out  CNT_W  valid instructions accepted into ID
//  bubble_count   out  CNT_W  bubbles inserted by flush_id
// BEHAVIOUR
//  - One clock, async active-high rst. On rst: pc=RESET_PC, id_instr=NOP_INSTR, id_pc=0,
//    id_pc_plus4=0, id_valid=0, both counters=0. Release takes effect at next rising edge.
//  - imem_addr = pc (no extra latency); pc_plus4 = pc + 32'd4, mod 2^32 (wraps, no trap).
//  - PC update per edge, priority: ex_pc_src -> pc=ex_pc_target; else stall_if -> hold;
//    else pc=pc_plus4. Redirect beats stall: the ID-stage instr is wrong-path anyway.
//  - ex_pc_target used as-is; bits [1:0] are not checked (alignment is EX's responsibility).
//  - IF/ID update per edge, priority: flush_id -> {NOP_INSTR,0,0,valid=0};
//    else stall_id -> hold all four fields; else {imem_rdata,pc,pc_plus4,valid=1}.
//  - Fetch-to-ID latency 1 cycle; taken-branch penalty 2 cycles (flush_id+flush_ex by hazard unit).
//  - Load-use: stall_if=stall_id=1 together -> PC and IF/ID both frozen for exactly that cycle;
//    the same imem word is re-read next cycle (imem is side-effect free).
//  - stall_id=1 with stall_if=0 is not produced by the hazard unit; if it occurs, PC advances and
//    the skipped word is lost (documented, not guarded).
//  - fetch_count += 1 on an edge where IF/ID captures (no flush, no stall). bubble_count += 1 on
//    an edge where flush_id=1. Both wrap at 2^CNT_W. Stall cycles count neither.
//  - rst mid-stall/mid-redirect: immediate return to reset state; pending redirect discarded.
// STRUCTURE
//  - Shared package core_pkg: NOP_INSTR, RESET_PC defaults, XLEN=32.
//  - One sub-module: pipe_reg_en_clr #(W,CLR_VAL) - async rst, sync clr (priority), enable;
//    instanced once for PC (clr unused) and once for the 97-bit IF/ID bundle {instr,pc,pc4,valid}.
//  - Counters and next-PC mux live in fetch_stage.
// TESTING
//  1 Reset: hold rst 3 cycles -> imem_addr=0, id_instr=32'h13, id_valid=0, counters=0;
//    release -> id_pc=0 after 1st edge, 4 after 2nd, id_valid=1.
//  2 Sequential: 8 cycles no stall -> id_pc steps 0,4,..,28; id_pc_plus4=id_pc+4; fetch_count=8.
//  3 Load-use: stall_if=stall_id=1 for 1 cycle at pc=0x10 -> imem_addr stays 0x10, id_* unchanged;
//    next edge id_pc=0x10; fetch_count not incremented during stall.
//  4 Redirect: ex_pc_src=1, flush_id=1, target=0x100 at pc=0x20 -> next edge imem_addr=0x100,
//    id_instr=32'h13, id_valid=0, bubble_count=1; following edge id_pc=0x100.
//  5 Redirect+stall same cycle (forced): ex_pc_src=1, stall_if=1, target=0x40 -> pc=0x40.
//  6 Wrap: RESET_PC=32'hFFFF_FFFC -> after 1 edge imem_addr=0; async rst asserted mid-cycle
//    during a stall -> outputs reset before next edge.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared definitions for the RV32I core: data width, reset PC,
//               NOP encoding and the IF/ID pipeline bundle layout.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;   // addi x0,x0,0

    // IF/ID bundle, MSB first: {instr, pc, pc_plus4, valid} = 97 bits
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

endpackage
`default_nettype wire

// File: rtl/pipe_reg_en_clr.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_en_clr
// Description : Generic pipeline register. Asynchronous reset, synchronous
//               clear that overrides enable, and a load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_en_clr #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register with priority rst > clr > en > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : IF stage and IF/ID register of the 5-stage RV32I core. Holds
//               the PC, addresses instruction memory, captures instr/PC into
//               ID, honours stall/flush/redirect and keeps perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             stall_id,
    input  logic             flush_id,
    input  logic             ex_pc_src,
    input  logic [31:0]      ex_pc_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_plus4,
    output logic             id_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] bubble_count
);

    localparam int           IFID_W    = $bits(ifid_t);
    localparam logic [96:0]  IFID_IDLE = {NOP_INSTR, 32'h0, 32'h0, 1'b0};

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        id_capture;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign pc_plus4  = pc + 32'd4;   // wraps modulo 2^32 by construction
    assign imem_addr = pc;

    // A redirect wins over a fetch stall: the instruction being held in ID
    // is on the wrong path, so there is nothing worth protecting.
    assign pc_en   = ex_pc_src | ~stall_if;
    assign pc_next = ex_pc_src ? ex_pc_target : pc_plus4;

    pipe_reg_en_clr #(
        .W       (32),
        .RST_VAL (RESET_PC),
        .CLR_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (pc_en),
        .d   (pc_next),
        .q   (pc)
    );

    // Flush (clr) dominates stall; a plain stall just freezes the bundle.
    assign ifid_d.instr    = imem_rdata;
    assign ifid_d.pc       = pc;
    assign ifid_d.pc_plus4 = pc_plus4;
    assign ifid_d.valid    = 1'b1;

    pipe_reg_en_clr #(
        .W       (IFID_W),
        .RST_VAL (IFID_IDLE),
        .CLR_VAL (IFID_IDLE)
    ) u_ifid_reg (
        .clk (clk),
        .rst (rst),
        .clr (flush_id),
        .en  (~stall_id),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_pc_plus4 = ifid_q.pc_plus4;
    assign id_valid    = ifid_q.valid;

    assign id_capture = ~flush_id & ~stall_id;

    // Performance counters: real captures and injected bubbles, free-running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (id_capture) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (flush_id) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage against a behavioural
//               model of the PC / IF-ID / counter rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_if = 1'b0;
    logic        stall_id = 1'b0;
    logic        flush_id = 1'b0;
    logic        ex_pc_src = 1'b0;
    logic [31:0] ex_pc_target = 32'h0;

    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count, bubble_count;

    logic [31:0] imem_addr2, imem_rdata2, id_instr2, id_pc2, id_pc_plus42;
    logic        id_valid2;
    logic [31:0] fetch_count2, bubble_count2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_fc, m_bc;
    logic        m_valid;

    // Deterministic instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata2 = mem_word(imem_addr2);

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target),
        .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .id_instr(id_instr2),
        .id_pc(id_pc2), .id_pc_plus4(id_pc_plus42), .id_valid(id_valid2),
        .fetch_count(fetch_count2), .bubble_count(bubble_count2)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h13; m_idpc = 0; m_idpc4 = 0;
        m_valid = 1'b0; m_fc = 0; m_bc = 0;
    endtask

    // Apply the architectural rules for one rising edge
    task automatic model_edge();
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (ex_pc_src)      m_pc = ex_pc_target;
        else if (!stall_if) m_pc = old_pc + 32'd4;
        if (flush_id) begin
            m_instr = 32'h13; m_idpc = 0; m_idpc4 = 0; m_valid = 1'b0;
            m_bc = m_bc + 1;
        end else if (!stall_id) begin
            m_instr = mem_word(old_pc); m_idpc = old_pc; m_idpc4 = old_pc + 32'd4;
            m_valid = 1'b1; m_fc = m_fc + 1;
        end
    endtask

    task automatic idle_inputs();
        stall_if = 0; stall_id = 0; flush_id = 0; ex_pc_src = 0; ex_pc_target = 0;
    endtask

    // Inputs are applied 1 time unit after an edge; outputs sampled likewise
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; #1;
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
        total++; if (id_instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=%h", id_instr, 32'h13); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (fetch_count !== 0 || bubble_count !== 0) begin bad++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0", fetch_count, bubble_count); end
        total++; if (id_pc !== 0 || id_pc_plus4 !== 0) begin bad++;
            $display("FAIL reset_idpc got=%h/%h exp=0/0", id_pc, id_pc_plus4); end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        total++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin bad++;
            $display("FAIL rel_edge1 got pc=%h v=%b exp pc=0 v=1", id_pc, id_valid); end
        tick();
        total++; if (id_pc !== 32'h4) begin bad++; $display("FAIL rel_edge2 got=%h exp=4", id_pc); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (id_pc !== 32'(i * 4) || id_pc_plus4 !== 32'(i * 4 + 4) ||
                         id_instr !== mem_word(32'(i * 4))) begin bad++;
                $display("FAIL seq_%0d got pc=%h p4=%h ins=%h exp pc=%h", i, id_pc, id_pc_plus4, id_instr, 32'(i * 4));
            end
        end
        total++; if (fetch_count !== 32'd8) begin bad++; $display("FAIL seq_fcount got=%0d exp=8", fetch_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        repeat (4) tick();
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL lu_pre got=%h exp=10", imem_addr); end
        stall_if = 1; stall_id = 1;
        tick();
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL lu_addr got=%h exp=10", imem_addr); end
        total++; if (id_pc !== 32'hC || id_instr !== mem_word(32'hC)) begin bad++;
            $display("FAIL lu_hold got pc=%h ins=%h exp pc=c", id_pc, id_instr); end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL lu_fcount got=%0d exp=4", fetch_count); end
        idle_inputs();
        tick();
        total++; if (id_pc !== 32'h10 || fetch_count !== 32'd5) begin bad++;
            $display("FAIL lu_after got pc=%h fc=%0d exp pc=10 fc=5", id_pc, fetch_count); end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (8) tick();
        ex_pc_src = 1; flush_id = 1; ex_pc_target = 32'h100;
        tick();
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
        total++; if (id_instr !== 32'h13 || id_valid !== 1'b0 || bubble_count !== 32'd1) begin bad++;
            $display("FAIL redir_bubble got ins=%h v=%b bc=%0d exp 13/0/1", id_instr, id_valid, bubble_count); end
        idle_inputs();
        tick();
        total++; if (id_pc !== 32'h100 || id_valid !== 1'b1) begin bad++;
            $display("FAIL redir_next got pc=%h v=%b exp 100/1", id_pc, id_valid); end
        ex_pc_src = 1; stall_if = 1; stall_id = 1; ex_pc_target = 32'h40;
        tick();
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_stall got=%h exp=40", imem_addr); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        total++; if (imem_addr2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_rst got=%h exp=fffffffc", imem_addr2); end
        @(posedge clk); #1;
        total++; if (imem_addr2 !== 32'h0 || id_pc_plus42 !== 32'h0) begin bad++;
            $display("FAIL wrap_addr got=%h p4=%h exp 0/0", imem_addr2, id_pc_plus42); end
        tick(); tick();
        stall_if = 1; stall_id = 1;
        @(posedge clk); #3;
        rst = 1'b1; #1;
        total++; if (imem_addr !== 0 || id_valid !== 0 || id_instr !== 32'h13 || fetch_count !== 0) begin bad++;
            $display("FAIL async_rst got a=%h v=%b ins=%h fc=%0d exp 0/0/13/0", imem_addr, id_valid, id_instr, fetch_count); end
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            idle_inputs();
            if (r < 15) begin
                stall_if = 1; stall_id = 1;
            end else if (r < 25) begin
                ex_pc_src = 1; flush_id = 1;
                ex_pc_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            end else if (r < 30) begin
                flush_id = 1;
            end else if (r < 33) begin
                stall_id = 1;
            end else if (r < 36) begin
                stall_if = 1; ex_pc_src = 1; ex_pc_target = $urandom;
            end
            tick();
            total++;
            if (imem_addr !== m_pc || id_instr !== m_instr || id_pc !== m_idpc ||
                id_pc_plus4 !== m_idpc4 || id_valid !== m_valid ||
                fetch_count !== m_fc || bubble_count !== m_bc) begin
                bad++;
                $display("FAIL rand_%0d got a=%h i=%h p=%h p4=%h v=%b fc=%0d bc=%0d exp a=%h i=%h p=%h p4=%h v=%b fc=%0d bc=%0d",
                         i, imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, fetch_count, bubble_count,
                         m_pc, m_instr, m_idpc, m_idpc4, m_valid, m_fc, m_bc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_load_use();
        test_redirect();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
